// File: rtl/onchip_mem_pkg.sv
// Shared constants and helpers for the dual-port pipelined on-chip RAM.
package onchip_mem_pkg;

  localparam int unsigned ONCHIP_MIN_LAT = 1;
  localparam int unsigned ONCHIP_MAX_LAT = 2;

  function automatic int unsigned bytes_of(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/onchip_mem_rd_pipe.sv
// Per-port read return pipeline: READ_LATENCY valid/data stages that freeze while
// clocken is low, with out-of-range reads returning zero.
module onchip_mem_rd_pipe #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clocken,
  input  logic                  rd_accept,
  input  logic                  oor,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid
);

  logic [READ_LATENCY-1:0]                 valid_q;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else if (clocken) begin
      valid_q[0] <= rd_accept;
      if (rd_accept) begin
        data_q[0] <= oor ? '0 : ram_rdata;
      end
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        valid_q[i] <= valid_q[i-1];
        // Data only moves with a valid read so the output word stays stable between reads
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  // Masking with clocken makes a stalled last stage emit its valid exactly once
  assign readdatavalid = valid_q[READ_LATENCY-1] & clocken;
  assign readdata      = data_q[READ_LATENCY-1];

endmodule

// File: rtl/onchip_memory_dp_pipelined.sv
// True-dual-port on-chip RAM with two Avalon-MM pipelined slave ports, byte lanes,
// s1-priority write collisions and a sticky out-of-range flag.
module onchip_memory_dp_pipelined
  import onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned DEPTH        = 80000,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "onchip_memory.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    oor_flag
);

  localparam int unsigned NumBytes = bytes_of(DATA_WIDTH);
  localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH == 0 || 64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must be non-zero and fit in ADDR_WIDTH");
  end
  if (READ_LATENCY < ONCHIP_MIN_LAT || READ_LATENCY > ONCHIP_MAX_LAT) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [NumBytes-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd;
    logic                  wr;
  } req_t;

  req_t                  req [2];
  logic                  clocken;
  logic [1:0]            accept, in_range, we, re, readdatavalid;
  logic [IdxWidth-1:0]   idx [2];
  logic [DATA_WIDTH-1:0] ram_rdata [2];
  logic [DATA_WIDTH-1:0] readdata [2];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  oor_q;

  // Chipselect is folded into rd/wr so the rest of the logic sees qualified requests
  assign req[0] = '{addr: s1_address, be: s1_byteenable, wdata: s1_writedata,
                    rd: s1_chipselect & s1_read, wr: s1_chipselect & s1_write};
  assign req[1] = '{addr: s2_address, be: s2_byteenable, wdata: s2_writedata,
                    rd: s2_chipselect & s2_read, wr: s2_chipselect & s2_write};

  assign clocken = clken & ~reset_req;

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign accept[p]    = (req[p].rd | req[p].wr) & clocken;
    assign in_range[p]  = 32'(req[p].addr) < DEPTH;
    assign we[p]        = accept[p] & req[p].wr & in_range[p];
    assign re[p]        = accept[p] & req[p].rd & ~req[p].wr;
    assign idx[p]       = req[p].addr[IdxWidth-1:0];
    assign ram_rdata[p] = mem[idx[p]];

    onchip_mem_rd_pipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY)
    ) u_rd_pipe (
      .clk          (clk),
      .reset        (reset),
      .clocken      (clocken),
      .rd_accept    (re[p]),
      .oor          (~in_range[p]),
      .ram_rdata    (ram_rdata[p]),
      .readdata     (readdata[p]),
      .readdatavalid(readdatavalid[p])
    );
  end

  // s2 skips a lane only when s1 writes that same lane of the same word
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NumBytes); k++) begin
      if (we[0] && req[0].be[k]) begin
        mem[idx[0]][8*k +: 8] <= req[0].wdata[8*k +: 8];
      end
      if (we[1] && req[1].be[k] && !(we[0] && req[0].be[k] && idx[0] == idx[1])) begin
        mem[idx[1]][8*k +: 8] <= req[1].wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oor_q <= 1'b0;
    end else if (|(accept & ~in_range)) begin
      oor_q <= 1'b1;
    end
  end

  assign oor_flag         = oor_q;
  assign s1_readdata      = readdata[0];
  assign s1_readdatavalid = readdatavalid[0];
  assign s1_waitrequest   = ~clocken;
  assign s2_readdata      = readdata[1];
  assign s2_readdatavalid = readdatavalid[1];
  assign s2_waitrequest   = ~clocken;

endmodule
